// File: rtl/conv_window_ctrl_if.sv
// Pixel-in and result-out handshake bundle for conv_window_ctrl.
// The slave modport is the controller side; the master modport is the pixel source / result sink.
interface conv_window_ctrl_if #(
  parameter int WIDTH_BIT = 8
);
  logic signed [WIDTH_BIT-1:0] pix_i;
  logic                        pix_valid;
  logic                        pix_ready;
  logic signed [WIDTH_BIT-1:0] res_o;
  logic                        res_valid;
  logic                        res_ready;

  modport master (
    output pix_i, pix_valid, res_ready,
    input  pix_ready, res_o, res_valid
  );

  modport slave (
    input  pix_i, pix_valid, res_ready,
    output pix_ready, res_o, res_valid
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Streaming SIZExSIZE window scheduler: line buffers, window register, one-deep result stage.
// Optional CONV_CTRL_STATS_EN adds the saturating win_count result counter.
module conv_window_ctrl #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic                                          clock,
  input  logic                                          nreset,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  conv_window_ctrl_if.slave                             strm,
  output logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_o,
  input  logic signed [WIDTH_BIT-1:0]                   conv_res_i
`ifdef CONV_CTRL_STATS_EN
  ,
  output logic [15:0]                                   win_count
`endif
);

  localparam int CW = $clog2(IMG_W > IMG_H ? IMG_W + 1 : IMG_H + 1);
  localparam int LB = (SIZE - 1) * IMG_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [CW-1:0]                row;
  logic [CW-1:0]                col;
  logic                         win_vld;
  logic                         res_vld;
  logic signed [WIDTH_BIT-1:0]  res_data;
  logic signed [WIDTH_BIT-1:0]  line_buf [LB];
  logic signed [WIDTH_BIT-1:0]  new_col [SIZE];
  logic                         pix_ready;
  logic                         accept;
  logic                         load;
  logic                         last_pix;
  logic                         win_full;
  logic                         drain_done;

  assign pix_ready  = (state == S_RUN) & (~win_vld | ~res_vld | strm.res_ready);
  assign accept     = strm.pix_valid & pix_ready;
  assign load       = win_vld & (~res_vld | strm.res_ready);
  assign last_pix   = accept & (row == CW'(IMG_H - 1)) & (col == CW'(IMG_W - 1));
  assign win_full   = accept & (row >= CW'(SIZE - 1)) & (col >= CW'(SIZE - 1));
  // Nothing left in flight, or the last outstanding result is being taken this edge.
  assign drain_done = ~win_vld & (~res_vld | strm.res_ready);

  assign strm.pix_ready = pix_ready;
  assign strm.res_o     = res_data;
  assign strm.res_valid = res_vld;

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)      state_nxt = S_RUN;  else state_nxt = S_IDLE;
      S_RUN:   if (last_pix)   state_nxt = S_DONE; else state_nxt = S_RUN;
      S_DONE:  if (drain_done) state_nxt = S_IDLE; else state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state == S_DONE) & drain_done;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      row <= '0;
      col <= '0;
    end else if ((state == S_IDLE) && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        if (row != CW'(IMG_H - 1)) row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffer is one long shift register; tap d*IMG_W-1 is the same column d rows up.
  always_ff @(posedge clock) begin
    if (accept) begin
      line_buf[0] <= strm.pix_i;
      for (int k = 1; k < LB; k++) line_buf[k] <= line_buf[k-1];
    end
  end

  // Incoming right-hand window column: buffer taps above, live pixel at the bottom.
  always_comb begin
    for (int i = 0; i < SIZE; i++) new_col[i] = '0;
    for (int i = 0; i < SIZE - 1; i++) new_col[i] = line_buf[(SIZE - 1 - i) * IMG_W - 1];
    new_col[SIZE-1] = strm.pix_i;
  end

  // Window shift and completion flag; a stalled window is frozen because accept is held off.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      win_o   <= '0;
      win_vld <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE - 1; j++) win_o[i][j] <= win_o[i][j+1];
          win_o[i][SIZE-1] <= new_col[i];
        end
      end
      if (win_full)  win_vld <= 1'b1;
      else if (load) win_vld <= 1'b0;
    end
  end

  // Result stage: capture the conv output of the current window.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      res_data <= '0;
      res_vld  <= 1'b0;
    end else if (load) begin
      res_data <= conv_res_i;
      res_vld  <= 1'b1;
    end else if (res_vld && strm.res_ready) begin
      res_vld  <= 1'b0;
    end
  end

`ifdef CONV_CTRL_STATS_EN
  // Saturating count of results handed off in the current frame.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      win_count <= 16'd0;
    end else if ((state == S_IDLE) && start) begin
      win_count <= 16'd0;
    end else if (res_vld && strm.res_ready && (win_count != 16'hFFFF)) begin
      win_count <= win_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized self-checking bench for conv_window_ctrl (SIZE=3, 8-bit, 4x4 frames, all-ones kernel).
// Expected results come from direct window sums over the stored frame image.
module tb_conv_window_ctrl;
  localparam int S  = 3;
  localparam int W  = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int NP = IW * IH;

  logic clock = 1'b0;
  logic nreset;
  logic start;
  logic busy;
  logic done;
  logic signed [S-1:0][S-1:0][W-1:0] win;
  logic signed [W-1:0] conv_res;
`ifdef CONV_CTRL_STATS_EN
  logic [15:0] win_count;
`endif

  conv_window_ctrl_if #(.WIDTH_BIT(W)) bus ();

  conv_window_ctrl #(.SIZE(S), .WIDTH_BIT(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .strm       (bus),
    .win_o      (win),
    .conv_res_i (conv_res)
`ifdef CONV_CTRL_STATS_EN
    ,
    .win_count  (win_count)
`endif
  );

  always #5 clock = ~clock;

  // Stand-in for the conv block: all-ones kernel means a plain sum, wrapped to 8 bits.
  always_comb begin
    logic [15:0] acc;
    acc = 16'd0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        acc = acc + {8'd0, win[i][j]};
    conv_res = acc[7:0];
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          got_cnt  = 0;
  logic [7:0]  img [NP];
  logic [7:0]  exp_q [$];
  bit          stall_prev = 1'b0;
  logic [7:0]  prev_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every valid window position in raster order, summed directly from the image.
  function automatic void build_expected();
    logic [15:0] s;
    exp_q.delete();
    for (int r = 0; r <= IH - S; r++)
      for (int c = 0; c <= IW - S; c++) begin
        s = 16'd0;
        for (int a = 0; a < S; a++)
          for (int b = 0; b < S; b++)
            s = s + {8'd0, img[(r + a) * IW + c + b]};
        exp_q.push_back(s[7:0]);
      end
  endfunction

  // Result scoreboard and output-hold checks.
  always @(negedge clock) begin
    if (!nreset) begin
      stall_prev = 1'b0;
    end else begin
      if (!busy) check("ready_when_idle", {31'd0, bus.pix_ready}, 32'd0);
      if (stall_prev) begin
        check("hold_valid", {31'd0, bus.res_valid}, 32'd1);
        check("hold_data", {24'd0, $unsigned(bus.res_o)}, {24'd0, prev_res});
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_result: got %0d expected none at %0t", bus.res_o, $time);
        end else begin
          check("result", {24'd0, $unsigned(bus.res_o)}, {24'd0, exp_q.pop_front()});
          got_cnt++;
        end
      end
      stall_prev = bus.res_valid && !bus.res_ready;
      prev_res   = bus.res_o;
    end
  end

  // img_mode: 0 ramp 1..16, 1 all 0x7F, 2 random. rr_mode: 0 ready, 1 random, 2 hold off then release.
  task automatic run_frame(input int img_mode, input int pv_mode, input int rr_mode,
                           input bit lat_chk, input bit mid_start, input int abort_at);
    int idx, cyc, k11, stall_cnt, n_exp;
    bit acc, got_done;
    int lit [4];
    lit = '{54, 63, 90, 99};
    for (int p = 0; p < NP; p++)
      img[p] = (img_mode == 0) ? 8'(p + 1) : (img_mode == 1) ? 8'h7F : 8'($urandom_range(0, 255));
    build_expected();
    n_exp = exp_q.size();
    if (img_mode == 0) for (int i = 0; i < 4; i++) check("model_ramp", {24'd0, exp_q[i]}, lit[i]);
    if (img_mode == 1) for (int i = 0; i < n_exp; i++) check("model_sat", {24'd0, exp_q[i]}, 32'h77);
    got_cnt = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("busy_after_start", {31'd0, busy}, 32'd1);
`ifdef CONV_CTRL_STATS_EN
    check("count_cleared", {16'd0, win_count}, 32'd0);
`endif
    @(posedge clock); #1;
    idx = 0; cyc = 0; k11 = -1; stall_cnt = 0; got_done = 1'b0;
    while (!got_done && cyc < 2000) begin
      bus.pix_valid = (idx < NP) && ((pv_mode == 0) || ($urandom_range(0, 3) != 0));
      bus.pix_i     = img[(idx < NP) ? idx : NP - 1];
      bus.res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? ($urandom_range(0, 1) == 1) : (stall_cnt >= 20);
      start         = mid_start && (idx == 5);
      @(negedge clock);
      acc = bus.pix_valid && bus.pix_ready;
      if (lat_chk && k11 >= 0 && cyc == k11) check("lat_early", {31'd0, bus.res_valid}, 32'd0);
      if (lat_chk && k11 >= 0 && cyc == k11 + 1) begin
        check("lat_valid", {31'd0, bus.res_valid}, 32'd1);
        check("lat_data", {24'd0, $unsigned(bus.res_o)}, 32'd54);
      end
      if (rr_mode == 2 && bus.res_valid && stall_cnt < 20) begin
        stall_cnt++;
        if (stall_cnt == 20) begin
          check("stall_ready", {31'd0, bus.pix_ready}, 32'd0);
          if (exp_q.size() > 0) check("stall_data", {24'd0, $unsigned(bus.res_o)}, {24'd0, exp_q[0]});
          if (img_mode == 0) check("stall_first", {24'd0, $unsigned(bus.res_o)}, 32'd54);
        end
      end
      if (done) got_done = 1'b1;
      @(posedge clock); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx == 11) k11 = cyc;
      end
      if (abort_at > 0 && idx == abort_at) break;
    end
    start = 1'b0;
    bus.pix_valid = 1'b0;
    if (abort_at > 0) begin
      nreset = 1'b0;
      @(posedge clock); #1;
      nreset = 1'b1;
      @(negedge clock);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("abort_ready", {31'd0, bus.pix_ready}, 32'd0);
      exp_q.delete();
      @(posedge clock); #1;
    end else begin
      if (!got_done) $display("FAIL timeout: got no done within %0d cycles", cyc);
      check("done_seen", {31'd0, got_done}, 32'd1);
      check("result_count", got_cnt, n_exp);
      check("queue_empty", exp_q.size(), 32'd0);
      @(negedge clock);
      check("busy_after_done", {31'd0, busy}, 32'd0);
`ifdef CONV_CTRL_STATS_EN
      check("count_frame", {16'd0, win_count}, n_exp);
`endif
      @(posedge clock); #1;
    end
  endtask

  initial begin
    nreset        = 1'b0;
    start         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_i     = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    nreset = 1'b1;
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_o", {24'd0, $unsigned(bus.res_o)}, 32'd0);
    check("rst_win_zero", {31'd0, (win == '0)}, 32'd1);
    check("rst_pix_ready", {31'd0, bus.pix_ready}, 32'd0);
    @(posedge clock); #1;

    run_frame(0, 0, 0, 1'b1, 1'b0, 0);
    run_frame(0, 0, 2, 1'b0, 1'b0, 0);
    run_frame(1, 0, 0, 1'b0, 1'b0, 0);
    run_frame(0, 0, 0, 1'b0, 1'b1, 7);
    run_frame(0, 0, 0, 1'b0, 1'b0, 0);
    for (int f = 0; f < 6; f++) run_frame(2, 1, (f % 2 == 0) ? 1 : 2, 1'b0, (f % 3 == 0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
